uart_rx_os_timer: RTL and testbench
===================================

// Module: uart_rx_os_timer
// PURPOSE
//  Parametrised oversampling timer for the UART receiver. It counts CLK edges within each bit and bits within each frame,
//  and emits three majority-vote sample strobes, a bit-done strobe and a frame-done strobe. Sits between the RX FSM
//  (drives enable, consumes strobes) and the data/parity/stop samplers. Supports any power-of-two prescale
//  4..MAX_PRESCALE and a runtime frame length. Flags illegal configuration.
// PARAMETERS
//  MAX_PRESCALE  32  largest legal prescale; power of two, >=4
//  PRESCALE_W    6   width of prescale input; must hold MAX_PRESCALE
//  EDGE_W        5   edge_cnt width = log2(MAX_PRESCALE)
//  BIT_W         4   bit_cnt / frame_bits width
// PORTS
//  CLK         in   1           clock
//  RST         in   1           reset, asynchronous, active-low
//  enable      in   1           run request from RX FSM; low = clear and idle
//  prescale    in   PRESCALE_W  oversampling ratio; legal = {4,8,..,MAX_PRESCALE}
//  frame_bits  in   BIT_W       bits per frame incl. start/parity/stop; legal 2..2^BIT_W-1
//  edge_cnt    out  EDGE_W      edge index within current bit, 0..ps-1
//  bit_cnt     out  BIT_W       bit index within current frame, 0..fb-1
//  sample_stb  out  1           high on edge_cnt = mid-1, mid, mid+1 (mid = ps/2)
//  sample_idx  out  2           0/1/2 = which of the three samples; 0 when sample_stb low
//  bit_done    out  1           high while edge_cnt == ps-1
//  frame_done  out  1           high while bit_done && bit_cnt == fb-1
//  cfg_err     out  1           illegal prescale/frame_bits captured at start
// BEHAVIOUR
//  - Reset: all counters 0, state IDLE, every output 0.
//  - FSM states: IDLE, RUN, ERR. enable low in any state -> IDLE at the next edge, counters cleared at that edge.
//  - IDLE & enable: live prescale/frame_bits are legal -> capture them into ps_q/fb_q and go to RUN. Illegal -> go to ERR.
//    The capture cycle is edge 0 of bit 0. Counters advance and strobes decode from the live inputs.
//  - RUN: use ps_q/fb_q only. Changes to prescale/frame_bits mid-frame are ignored until enable drops and reasserts.
//  - edge_cnt +1 per enabled cycle. At ps-1 it wraps to 0 and bit_cnt increments.
//  - At bit_cnt == fb-1 with bit_done, bit_cnt wraps to 0. Counting continues while enable is held
//    (back-to-back frames, no gap cycle).
//  - ERR: counters held 0, all strobes 0. cfg_err = 1 from the cycle after capture until enable drops.
//  - Strobes/flags are combinational decodes of registered state (and of live inputs in IDLE). They are gated by
//    enable, so they are 0 whenever enable is low.
//  - Widths: ps-1 and mid computed at EDGE_W+1 bits. prescale = MAX_PRESCALE fits because edge_cnt max = ps-1.
//  - Async RST low mid-frame: immediate clear. Resume requires a fresh enable start.
// STRUCTURE
//  - Shared package uart_pkg: state enum (IDLE/RUN/ERR), MIN_PRESCALE = 4, function is_legal_prescale(ps, max)
//    (power-of-two and range check), and function sample_mid(ps).
//  - One sub-module, uart_presc_check: combinational legality of prescale/frame_bits. Produces legal, mid and last_edge.
//    Reused by the TX baud generator.
// TESTING
//  - ps=8, fb=10, enable 80 cycles -> sample_stb at edges 3,4,5 of every bit (idx 0,1,2); bit_done every 8th cycle;
//    frame_done only at cycle 79; bit_cnt 0..9 then 0.
//  - ps=16, fb=11 -> samples at edges 7,8,9; bit_done period 16; frame_done at cycle 175; second frame starts at cycle 176.
//  - ps=4 -> samples at 1,2,3; bit_done at edge 3. ps=32 -> samples 15,16,17; edge_cnt reaches 31 without overflow.
//  - ps=6, or fb=1, at enable -> cfg_err=1 from the next cycle, edge_cnt/bit_cnt stay 0, no strobes;
//    enable low -> cfg_err 0 next cycle.
//  - Start with ps=8, switch input to 4 at bit 2 -> timing stays 8. Drop enable, reassert -> period 4.
//  - enable low at bit 3/edge 5 -> counters 0 next edge, strobes 0 immediately;
//    RST low mid-frame -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART timing definitions: FSM state encoding and prescale helpers.
// Pure declarations; no latency, no backpressure.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        ERR  = 2'd2
    } state_t;

    localparam logic [31:0] MIN_PRESCALE = 32'd4;

    // Power of two within [MIN_PRESCALE, max_ps].
    function automatic logic is_legal_prescale(input logic [31:0] ps, input logic [31:0] max_ps);
        return (ps >= MIN_PRESCALE) && (ps <= max_ps) && ((ps & (ps - 32'd1)) == 32'd0);
    endfunction

    function automatic logic [31:0] sample_mid(input logic [31:0] ps);
        return ps >> 1;
    endfunction

endpackage

// File: rtl/uart_presc_check.sv
// Combinational prescale/frame-length legality plus the derived mid-sample and last-edge indices.
// Zero latency; no backpressure.
module uart_presc_check
    import uart_pkg::*;
#(
    parameter int MAX_PRESCALE = 32,
    parameter int PRESCALE_W   = 6,
    parameter int EDGE_W       = 5,
    parameter int BIT_W        = 4
) (
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic [BIT_W-1:0]      frame_bits,
    output logic                  legal,
    output logic [EDGE_W:0]       mid,
    output logic [EDGE_W:0]       last_edge
);

    logic ps_ok;
    logic fb_ok;

    assign ps_ok = is_legal_prescale(32'(prescale), 32'(MAX_PRESCALE));
    // A frame needs at least a start and a stop bit.
    assign fb_ok = (frame_bits >= BIT_W'(2));
    assign legal = ps_ok && fb_ok;

    // One bit wider than edge_cnt so prescale = MAX_PRESCALE still fits.
    assign mid       = (EDGE_W+1)'(sample_mid(32'(prescale)));
    assign last_edge = (EDGE_W+1)'(prescale) - (EDGE_W+1)'(1);

endmodule

// File: rtl/uart_rx_os_timer.sv
// Oversampling bit/frame timer for the UART receiver: counts edges per bit and bits per frame, decodes sample strobes.
// Strobes are same-cycle decodes of registered counters; no backpressure, enable low clears at the next edge.
module uart_rx_os_timer
    import uart_pkg::*;
#(
    parameter int MAX_PRESCALE = 32,
    parameter int PRESCALE_W   = 6,
    parameter int EDGE_W       = 5,
    parameter int BIT_W        = 4
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  enable,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic [BIT_W-1:0]      frame_bits,
    output logic [EDGE_W-1:0]     edge_cnt,
    output logic [BIT_W-1:0]      bit_cnt,
    output logic                  sample_stb,
    output logic [1:0]            sample_idx,
    output logic                  bit_done,
    output logic                  frame_done,
    output logic                  cfg_err
);

    state_t                state;
    logic [PRESCALE_W-1:0] ps_q;
    logic [BIT_W-1:0]      fb_q;

    logic [PRESCALE_W-1:0] eff_ps;
    logic [BIT_W-1:0]      eff_fb;
    logic [BIT_W-1:0]      fb_last;
    logic                  legal;
    logic [EDGE_W:0]       mid;
    logic [EDGE_W:0]       mid_lo;
    logic [EDGE_W:0]       mid_hi;
    logic [EDGE_W:0]       last_edge;
    logic [EDGE_W:0]       e_ext;
    logic                  run_ok;
    logic                  at_last;
    logic                  at_frame_end;

    // The start cycle runs from the live inputs; afterwards only the captured copy is used.
    assign eff_ps = (state == RUN) ? ps_q : prescale;
    assign eff_fb = (state == RUN) ? fb_q : frame_bits;

    uart_presc_check #(
        .MAX_PRESCALE (MAX_PRESCALE),
        .PRESCALE_W   (PRESCALE_W),
        .EDGE_W       (EDGE_W),
        .BIT_W        (BIT_W)
    ) u_presc_check (
        .prescale   (eff_ps),
        .frame_bits (eff_fb),
        .legal      (legal),
        .mid        (mid),
        .last_edge  (last_edge)
    );

    assign e_ext        = {1'b0, edge_cnt};
    assign mid_lo       = mid - (EDGE_W+1)'(1);
    assign mid_hi       = mid + (EDGE_W+1)'(1);
    assign fb_last      = eff_fb - BIT_W'(1);
    assign at_last      = (e_ext == last_edge);
    assign at_frame_end = (bit_cnt == fb_last);
    assign run_ok       = enable && ((state == RUN) || ((state == IDLE) && legal));

    always_comb begin
        sample_stb = 1'b0;
        sample_idx = 2'd0;
        bit_done   = 1'b0;
        frame_done = 1'b0;
        if (run_ok) begin
            if (e_ext == mid_lo) begin
                sample_stb = 1'b1;
                sample_idx = 2'd0;
            end else if (e_ext == mid) begin
                sample_stb = 1'b1;
                sample_idx = 2'd1;
            end else if (e_ext == mid_hi) begin
                sample_stb = 1'b1;
                sample_idx = 2'd2;
            end
            bit_done   = at_last;
            frame_done = at_last && at_frame_end;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state    <= IDLE;
            ps_q     <= '0;
            fb_q     <= '0;
            edge_cnt <= '0;
            bit_cnt  <= '0;
            cfg_err  <= 1'b0;
        end else if (!enable) begin
            state    <= IDLE;
            edge_cnt <= '0;
            bit_cnt  <= '0;
            cfg_err  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (legal) begin
                        state <= RUN;
                        ps_q  <= prescale;
                        fb_q  <= frame_bits;
                    end else begin
                        state   <= ERR;
                        cfg_err <= 1'b1;
                    end
                end
                RUN: ;
                default: begin
                    edge_cnt <= '0;
                    bit_cnt  <= '0;
                end
            endcase
            // Counting also covers the capture cycle, which is edge 0 of bit 0.
            if (run_ok) begin
                if (at_last) begin
                    edge_cnt <= '0;
                    bit_cnt  <= at_frame_end ? '0 : bit_cnt + BIT_W'(1);
                end else begin
                    edge_cnt <= edge_cnt + EDGE_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_os_timer.sv
// Scoreboard bench for uart_rx_os_timer: directed runs push expected outputs, a negedge monitor compares.
module tb_uart_rx_os_timer;

    logic       CLK = 1'b0;
    logic       RST;
    logic       enable;
    logic [5:0] prescale;
    logic [3:0] frame_bits;
    logic [4:0] edge_cnt;
    logic [3:0] bit_cnt;
    logic       sample_stb;
    logic [1:0] sample_idx;
    logic       bit_done;
    logic       frame_done;
    logic       cfg_err;

    uart_rx_os_timer dut (
        .CLK        (CLK),
        .RST        (RST),
        .enable     (enable),
        .prescale   (prescale),
        .frame_bits (frame_bits),
        .edge_cnt   (edge_cnt),
        .bit_cnt    (bit_cnt),
        .sample_stb (sample_stb),
        .sample_idx (sample_idx),
        .bit_done   (bit_done),
        .frame_done (frame_done),
        .cfg_err    (cfg_err)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [4:0] e;
        logic [3:0] b;
        logic       stb;
        logic [1:0] idx;
        logic       bd;
        logic       fd;
        logic       err;
    } obs_t;

    obs_t q[$];
    obs_t mon_exp;
    obs_t mon_act;
    int   checks = 0;
    int   errors = 0;
    int   step_no = 0;

    // Reference model: n = enabled cycles since start, captured ps/fb, error latch.
    int n = 0;
    bit started = 0;
    bit errmode = 0;
    bit err_reg = 0;
    int cps = 8;
    int cfb = 10;

    function automatic bit live_legal(int ps, int fb);
        return (ps == 4 || ps == 8 || ps == 16 || ps == 32) && fb >= 2;
    endfunction

    function automatic obs_t predict(bit en, int ps, int fb);
        obs_t o;
        int eps, efb, e, b, mid;
        o = '0;
        eps = started ? cps : ps;
        efb = started ? cfb : fb;
        if (eps < 1) eps = 1;
        if (efb < 1) efb = 1;
        e = n % eps;
        b = (n / eps) % efb;
        o.e = e[4:0];
        o.b = b[3:0];
        o.err = err_reg;
        if (en && !errmode && (started || live_legal(ps, fb))) begin
            mid = eps / 2;
            if (e >= mid - 1 && e <= mid + 1) begin
                o.stb = 1'b1;
                o.idx = 2'(e - (mid - 1));
            end
            o.bd = (e == eps - 1);
            o.fd = o.bd && (b == efb - 1);
        end
        return o;
    endfunction

    task automatic step(input bit en, input int ps, input int fb);
        @(posedge CLK);
        #1;
        enable     = en;
        prescale   = 6'(ps);
        frame_bits = 4'(fb);
        q.push_back(predict(en, ps, fb));
        if (!en) begin
            n = 0; started = 0; errmode = 0; err_reg = 0;
        end else if (started) begin
            n++;
        end else if (!errmode) begin
            if (live_legal(ps, fb)) begin
                started = 1; cps = ps; cfb = fb; n = 1;
            end else begin
                errmode = 1; err_reg = 1;
            end
        end
    endtask

    task automatic run(input int ps, input int fb, input int cycles);
        for (int i = 0; i < cycles; i++) step(1'b1, ps, fb);
    endtask

    always @(negedge CLK) begin
        if (q.size() > 0) begin
            mon_exp = q.pop_front();
            mon_act = {edge_cnt, bit_cnt, sample_stb, sample_idx, bit_done, frame_done, cfg_err};
            step_no++;
            checks++;
            if (mon_act !== mon_exp) begin
                errors++;
                $display("FAIL step%0d: got e=%0d b=%0d stb=%0b idx=%0d bd=%0b fd=%0b err=%0b, need e=%0d b=%0d stb=%0b idx=%0d bd=%0b fd=%0b err=%0b",
                         step_no, mon_act.e, mon_act.b, mon_act.stb, mon_act.idx, mon_act.bd, mon_act.fd, mon_act.err,
                         mon_exp.e, mon_exp.b, mon_exp.stb, mon_exp.idx, mon_exp.bd, mon_exp.fd, mon_exp.err);
            end
        end
    end

    task automatic check_all_zero(input string name);
        checks++;
        if ({edge_cnt, bit_cnt, sample_stb, sample_idx, bit_done, frame_done, cfg_err} !== '0) begin
            errors++;
            $display("FAIL %s: got e=%0d b=%0d stb=%0b idx=%0d bd=%0b fd=%0b err=%0b, need all zero",
                     name, edge_cnt, bit_cnt, sample_stb, sample_idx, bit_done, frame_done, cfg_err);
        end
    endtask

    initial begin
        RST = 1'b0;
        enable = 1'b0;
        prescale = 6'd8;
        frame_bits = 4'd10;
        #12;
        check_all_zero("reset");
        @(negedge CLK);
        RST = 1'b1;

        // ps=8 fb=10: one full frame plus wrap into the next
        run(8, 10, 82);
        step(1'b0, 8, 10);
        // ps=16 fb=11: frame_done at cycle 175, second frame from 176
        run(16, 11, 180);
        step(1'b0, 16, 11);
        // smallest and largest prescale
        run(4, 10, 20);
        step(1'b0, 4, 10);
        run(32, 3, 70);
        step(1'b0, 32, 3);
        // illegal prescale, then illegal frame length
        run(6, 10, 4);
        step(1'b0, 6, 10);
        step(1'b0, 6, 10);
        run(8, 1, 3);
        step(1'b0, 8, 1);
        step(1'b0, 8, 1);
        // mid-frame prescale change ignored until restart
        run(8, 10, 16);
        run(4, 10, 20);
        step(1'b0, 4, 10);
        run(4, 10, 10);
        step(1'b0, 4, 10);
        // enable drop at bit 3 / edge 5
        run(8, 10, 29);
        step(1'b0, 8, 10);
        step(1'b0, 8, 10);
        // asynchronous reset mid-frame
        run(8, 10, 13);
        @(negedge CLK);
        #1;
        RST = 1'b0;
        #1;
        check_all_zero("async_reset");
        n = 0; started = 0; errmode = 0; err_reg = 0;
        enable = 1'b0;
        RST = 1'b1;
        step(1'b0, 8, 10);
        run(8, 10, 10);
        step(1'b0, 8, 10);

        @(negedge CLK);
        #1;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending entries, need 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
